fetch_stage: RTL and testbench

- Fetch unit and IF/ID pipeline register for the 5-stage MIPS core.
- Consumes the stall/flush controls produced by the hazard unit: pc_stall, and if_ctrl with 00=advance, 01=hold, 10=flush.
- Consumes the branch redirect from MEM.
- Drives the instruction-memory request/acknowledge handshake and presents the fetched instruction to ID.
- Reports memory-wait back to the hazard unit through fetch_busy.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_stage_if.sv | 24 ++
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: hazard-unit control encodings,
// fetch FSM states, IF/ID register select codes and the bubble instruction.
package fetch_pkg;

    localparam logic [1:0] IFC_ADVANCE = 2'b00;
    localparam logic [1:0] IFC_HOLD    = 2'b01;
    localparam logic [1:0] IFC_FLUSH   = 2'b10;

    // All-zero word decodes as sll $0,$0,0 on MIPS, i.e. a harmless NOP.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_BUF   = 2'd1,
        S_KILL  = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        ID_HOLD   = 2'd0,
        ID_LOAD   = 2'd1,
        ID_BUBBLE = 2'd2
    } id_sel_e;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a new instruction, holds the current one,
// or inserts a bubble (valid cleared, NOP instruction, PC fields kept).
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  id_sel_e     sel,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst
);

    // IF/ID register update according to the load/hold/bubble select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_pc       <= 32'h0000_0000;
            id_pc_plus4 <= 32'h0000_0000;
            id_inst     <= NOP_INST;
        end else begin
            unique case (sel)
                ID_LOAD: begin
                    id_valid    <= 1'b1;
                    id_pc       <= load_pc;
                    id_pc_plus4 <= load_pc + 32'd4;
                    id_inst     <= load_inst;
                end
                ID_BUBBLE: begin
                    id_valid <= 1'b0;
                    id_inst  <= NOP_INST;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch unit and IF/ID register for the 5-stage MIPS core.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_wait counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall,
    input  logic [1:0]  if_ctrl,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    fetch_stage_if.master imem,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst,
    output logic        fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_wait
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  buf_pc, buf_inst;
    logic         buf_load;
    id_sel_e      id_sel;
    logic [31:0]  ld_pc, ld_inst;

    logic advance, flush, hold, active, ack;

    assign advance = (if_ctrl == IFC_ADVANCE) && !pc_stall;
    assign flush   = (if_ctrl == IFC_FLUSH) || (if_ctrl == 2'b11);
    assign hold    = (if_ctrl == IFC_HOLD);
    assign active  = (state_q == S_FETCH) || (state_q == S_KILL);
    // Acks are only meaningful while a request is on the bus.
    assign ack     = active && imem.imem_ack;

    // Request is suppressed while reset is held so the first one appears after release.
    assign imem.imem_req  = !rst && active;
    assign imem.imem_addr = req_addr_q;
    assign fetch_busy     = !rst && (((state_q == S_FETCH) && !imem.imem_ack) ||
                                     (state_q == S_KILL));

    // Control registers: FSM state, fetch PC and outstanding request address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Skid buffer for an instruction that arrives while ID cannot accept it
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_pc   <= pc_q;
            buf_inst <= imem.imem_rdata;
        end
    end

    // Next-state, PC update and IF/ID select; redirect overrides everything
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_load   = 1'b0;
        id_sel     = ID_HOLD;
        ld_pc      = pc_q;
        ld_inst    = imem.imem_rdata;

        if (redirect_valid) begin
            pc_d   = word_align(redirect_pc);
            id_sel = ID_BUBBLE;
            if (active && !ack) begin
                // A stale request is in flight: drain it before re-targeting.
                state_d = S_KILL;
            end else begin
                req_addr_d = word_align(redirect_pc);
                state_d    = S_FETCH;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (ack && advance) begin
                        id_sel     = ID_LOAD;
                        pc_d       = pc_q + 32'd4;
                        req_addr_d = pc_q + 32'd4;
                    end else begin
                        if (ack) begin
                            buf_load = 1'b1;
                            state_d  = S_BUF;
                        end
                        // Advancing with nothing fetched leaves a bubble.
                        id_sel = (flush || advance) ? ID_BUBBLE : ID_HOLD;
                    end
                end
                S_BUF: begin
                    if (advance) begin
                        id_sel     = ID_LOAD;
                        ld_pc      = buf_pc;
                        ld_inst    = buf_inst;
                        pc_d       = buf_pc + 32'd4;
                        req_addr_d = buf_pc + 32'd4;
                        state_d    = S_FETCH;
                    end else begin
                        id_sel = flush ? ID_BUBBLE : ID_HOLD;
                    end
                end
                S_KILL: begin
                    if (ack) begin
                        req_addr_d = pc_q;
                        state_d    = S_FETCH;
                    end
                    id_sel = hold ? ID_HOLD : ID_BUBBLE;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .sel         (id_sel),
        .load_pc     (ld_pc),
        .load_inst   (ld_inst),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_inst     (id_inst)
    );

`ifdef FETCH_PERF_EN
    // Wrapping counters of valid IF/ID loads and memory-wait cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'h0;
            perf_wait    <= 32'h0;
        end else begin
            if (id_sel == ID_LOAD) perf_fetched <= perf_fetched + 32'd1;
            if (fetch_busy)        perf_wait    <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable instruction memory,
// directed phases pushing expected IF/ID loads, and a decoupled monitor.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_stall = 1'b0;
    logic [1:0]  if_ctrl = 2'b00;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc, id_pc_plus4, id_inst;
    logic        fetch_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_wait;
`endif

    fetch_stage_if bus ();

    int n_chk = 0;
    int n_fail = 0;
    int lat = 0;
    int wcnt = 0;
    logic [31:0] exp_q[$];
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = 32'h0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_stall       (pc_stall),
        .if_ctrl        (if_ctrl),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus.master),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_inst        (id_inst),
        .fetch_busy     (fetch_busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_wait      (perf_wait)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h2408_0000;
    endfunction

    // Memory: acks after 'lat' waiting cycles, data is a function of the address
    assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every new valid IF/ID content must match the next expected PC
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (id_valid && (!prev_v || id_pc != prev_pc)) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_load: got pc %h, expected no load (t=%0t)", id_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc", id_pc, e);
                    chk("mon_pc_plus4", id_pc_plus4, e + 32'd4);
                    chk("mon_inst", id_inst, mem_word(e));
                end
            end
            prev_v  <= id_valid;
            prev_pc <= id_pc;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        pc_stall = 1'b0;
        if_ctrl = IFC_ADVANCE;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_inst", id_inst, NOP_WORD);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait memory from reset: one instruction per cycle
        lat = 0;
        reset_dut();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        @(negedge clk);
        chk("a_first_req", {31'b0, bus.imem_req}, 32'd1);
        chk("a_first_addr", bus.imem_addr, 32'h0);
        chk("a_first_valid", {31'b0, id_valid}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            @(negedge clk);
            chk("a_valid", {31'b0, id_valid}, 32'd1);
            chk("a_pc", id_pc, 32'(4 * k));
            chk("a_busy", {31'b0, fetch_busy}, 32'd0);
        end
        #1 rst = 1'b1;

        // Two wait cycles per request
        lat = 2;
        reset_dut();
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(4 * k));
        for (int c = 1; c <= 12; c++) begin
            int k, r;
            k = (c - 1) / 3;
            r = (c - 1) % 3;
            if (c > 1) next_cycle();
            @(negedge clk);
            chk("b_busy", {31'b0, fetch_busy}, (r != 2) ? 32'd1 : 32'd0);
            chk("b_addr", bus.imem_addr, 32'(4 * k));
            chk("b_valid", {31'b0, id_valid}, (r == 0 && k > 0) ? 32'd1 : 32'd0);
            if (r == 0 && k > 0) chk("b_pc", id_pc, 32'(4 * (k - 1)));
            else chk("b_bubble_inst", id_inst, NOP_WORD);
        end
        #1 rst = 1'b1;

        // Ack while ID stalled: instruction parked in the buffer
        lat = 0;
        reset_dut();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        @(negedge clk);
        chk("c_req1", {31'b0, bus.imem_req}, 32'd1);
        next_cycle();
        if_ctrl = IFC_HOLD;
        pc_stall = 1'b1;
        @(negedge clk);
        chk("c_addr2", bus.imem_addr, 32'h4);
        chk("c_ack2", {31'b0, bus.imem_ack}, 32'd1);
        for (int c = 3; c <= 4; c++) begin
            next_cycle();
            @(negedge clk);
            chk("c_stall_req", {31'b0, bus.imem_req}, 32'd0);
            chk("c_stall_valid", {31'b0, id_valid}, 32'd1);
            chk("c_stall_pc", id_pc, 32'h0);
            chk("c_stall_busy", {31'b0, fetch_busy}, 32'd0);
        end
        next_cycle();
        if_ctrl = IFC_ADVANCE;
        pc_stall = 1'b0;
        @(negedge clk);
        chk("c_rel_req", {31'b0, bus.imem_req}, 32'd0);
        chk("c_rel_pc", id_pc, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("c_buf_pc", id_pc, 32'h4);
        chk("c_buf_inst", id_inst, mem_word(32'h4));
        chk("c_next_req", {31'b0, bus.imem_req}, 32'd1);
        chk("c_next_addr", bus.imem_addr, 32'h8);
        next_cycle();
        @(negedge clk);
        chk("c_after_pc", id_pc, 32'h8);
        #1 rst = 1'b1;

        // Redirect while the request to 0x20 is outstanding
        lat = 0;
        reset_dut();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        exp_q.push_back(32'h100);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) next_cycle();
            @(negedge clk);
            chk("d_addr", bus.imem_addr, 32'(4 * (c - 1)));
        end
        next_cycle();
        lat = 2;
        @(negedge clk);
        chk("d_addr20", bus.imem_addr, 32'h20);
        chk("d_busy9", {31'b0, fetch_busy}, 32'd1);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("d_addr_hold", bus.imem_addr, 32'h20);
        chk("d_valid10", {31'b0, id_valid}, 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("d_kill_req", {31'b0, bus.imem_req}, 32'd1);
        chk("d_kill_addr", bus.imem_addr, 32'h20);
        chk("d_kill_ack", {31'b0, bus.imem_ack}, 32'd1);
        chk("d_kill_busy", {31'b0, fetch_busy}, 32'd1);
        chk("d_kill_valid", {31'b0, id_valid}, 32'd0);
        for (int c = 12; c <= 14; c++) begin
            next_cycle();
            @(negedge clk);
            chk("d_new_addr", bus.imem_addr, 32'h100);
            chk("d_new_valid", {31'b0, id_valid}, 32'd0);
            chk("d_new_busy", {31'b0, fetch_busy}, (c == 14) ? 32'd0 : 32'd1);
        end
        next_cycle();
        @(negedge clk);
        chk("d_target_valid", {31'b0, id_valid}, 32'd1);
        chk("d_target_pc", id_pc, 32'h100);
        #1 rst = 1'b1;

        // Reset asserted mid-wait
        lat = 2;
        reset_dut();
        exp_q.push_back(32'h0);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) next_cycle();
            @(negedge clk);
            if (c == 4) chk("e_pc_before", id_pc, 32'h0);
        end
        chk("e_waiting", {31'b0, fetch_busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("e_async_valid", {31'b0, id_valid}, 32'd0);
        chk("e_async_inst", id_inst, NOP_WORD);
        chk("e_async_pc", id_pc, 32'h0);
        chk("e_async_pc4", id_pc_plus4, 32'h0);
        chk("e_async_req", {31'b0, bus.imem_req}, 32'd0);
        reset_dut();
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("e_first_req", {31'b0, bus.imem_req}, 32'd1);
        chk("e_first_addr", bus.imem_addr, 32'h0);
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            @(negedge clk);
        end
        chk("e_reload_pc", id_pc, 32'h0);
        #1 rst = 1'b1;

`ifdef FETCH_PERF_EN
        // Ten instructions at one wait cycle each
        lat = 1;
        reset_dut();
        for (int k = 0; k < 10; k++) exp_q.push_back(32'(4 * k));
        for (int c = 1; c <= 21; c++) begin
            if (c > 1) next_cycle();
            @(negedge clk);
        end
        chk("f_perf_fetched", perf_fetched, 32'd10);
        chk("f_perf_wait", perf_wait, 32'd10);
        #1 rst = 1'b1;
`endif

        @(negedge clk);
        chk("final_queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
